power_up_scheduler: RTL and testbench

//  Sequences item spawning for the three power-up item generators (0 speed-up, 1 extra bomb, 2 bomb range).

---
 rtl/power_up_scheduler.sv | 137 +++++++++++++
 tb/tb_power_up_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_up_scheduler.sv
// Power-up item spawn sequencer: buffers freed-block events, rolls each against an LFSR
// threshold and hands winners round-robin to a free, unreserved item generator slot.
module power_up_scheduler #(
    parameter int unsigned NUM_ROW     = 11,
    parameter int unsigned NUM_COL     = 19,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2024,
    parameter int unsigned RSV_TIMEOUT = 4,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL),
    localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  free_we,
    input  logic [ADDR_WIDTH-1:0] free_addr,
    input  logic [31:0]           probability,
    input  logic [2:0]            slot_active,
    output logic [2:0]            gen_we,
    output logic [ADDR_WIDTH-1:0] gen_addr,
    output logic [CNT_WIDTH-1:0]  fifo_count,
    output logic [7:0]            drop_cnt,
    output logic                  busy
);

    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned TMR_WIDTH = $clog2(RSV_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRoll, StPick, StIssue} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [31:0]           lfsr_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [1:0]            rr_ptr_q, sel_q;
    logic [2:0]            reserve_q;
    logic [TMR_WIDTH-1:0]  rsv_tmr_q [3];

    logic       pop, push, drop, full, spawn;
    logic [2:0] avail;
    logic       pick_found;
    logic [1:0] pick_sel;
    logic [2:0] idx;

    assign full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
    assign pop   = (state_q == StIdle) && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = free_we && (!full || pop);
    assign drop  = free_we && full && !pop;
    assign spawn = (probability == 32'hFFFF_FFFF) || (lfsr_q < probability);
    assign avail = ~slot_active & ~reserve_q;

    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

    always_comb begin
        pick_found = 1'b0;
        pick_sel   = 2'd0;
        idx        = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, rr_ptr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!pick_found && avail[idx[1:0]]) begin
                pick_found = 1'b1;
                pick_sel   = idx[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            cur_addr_q <= '0;
            rr_ptr_q   <= 2'd0;
            sel_q      <= 2'd0;
            reserve_q  <= 3'b000;
            for (int i = 0; i < 3; i++) rsv_tmr_q[i] <= '0;
            gen_we     <= 3'b000;
            gen_addr   <= '0;
            drop_cnt   <= 8'd0;
        end else begin
            lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
            gen_we <= 3'b000;

            if (push) begin
                mem_q[wr_ptr_q] <= free_addr;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + CNT_WIDTH'(1);
            else if (pop && !push) count_q <= count_q - CNT_WIDTH'(1);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

            // Reservation ends once the generator acknowledges or the wait times out.
            for (int i = 0; i < 3; i++) begin
                if (reserve_q[i]) begin
                    if (slot_active[i] || rsv_tmr_q[i] == TMR_WIDTH'(1)) reserve_q[i] <= 1'b0;
                    else rsv_tmr_q[i] <= rsv_tmr_q[i] - TMR_WIDTH'(1);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        cur_addr_q <= mem_q[rd_ptr_q];
                        state_q    <= StRoll;
                    end
                end
                StRoll: state_q <= spawn ? StPick : StIdle;
                StPick: begin
                    if (pick_found) begin
                        sel_q    <= pick_sel;
                        gen_we   <= 3'b001 << pick_sel;
                        gen_addr <= cur_addr_q;
                        state_q  <= StIssue;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StIssue: begin
                    reserve_q[sel_q] <= 1'b1;
                    rsv_tmr_q[sel_q] <= TMR_WIDTH'(RSV_TIMEOUT);
                    rr_ptr_q         <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_power_up_scheduler.sv
// Bench for power_up_scheduler: transaction-level model (event queue, time-stamped
// event progress, absolute-time reservation windows) compared against the DUT every cycle.
module tb_power_up_scheduler;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RSV   = 4;
    localparam logic [31:0] SEED  = 32'hACE1_2024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          free_we = 1'b0;
    logic [AW-1:0] free_addr = '0;
    logic [31:0]   probability = '0;
    logic [2:0]    slot_active = '0;
    logic [2:0]    gen_we;
    logic [AW-1:0] gen_addr;
    logic [2:0]    fifo_count;
    logic [7:0]    drop_cnt;
    logic          busy;

    power_up_scheduler #(
        .NUM_ROW(11), .NUM_COL(19), .FIFO_DEPTH(DEPTH), .LFSR_SEED(SEED), .RSV_TIMEOUT(RSV)
    ) dut (
        .clk(clk), .rst(rst), .free_we(free_we), .free_addr(free_addr),
        .probability(probability), .slot_active(slot_active), .gen_we(gen_we),
        .gen_addr(gen_addr), .fifo_count(fifo_count), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          t;
    int          m_q[$];
    bit          m_inflight;
    int          m_tp;
    int          m_cur;
    int          m_sel;
    int          m_rr;
    int          m_rsv_from[3];
    int          m_rsv_end[3];
    logic [31:0] m_lfsr;
    logic [2:0]  m_we;
    logic [AW-1:0] m_addr;
    int          m_drop;
    logic        m_busy;

    task automatic model_reset();
        t = 0; m_q.delete(); m_inflight = 0; m_tp = 0; m_cur = 0; m_sel = 0; m_rr = 0;
        for (int i = 0; i < 3; i++) begin m_rsv_from[i] = 0; m_rsv_end[i] = 0; end
        m_lfsr = SEED; m_we = '0; m_addr = '0; m_drop = 0; m_busy = 0;
    endtask

    function automatic bit reserved(int s, int now);
        return (m_rsv_from[s] < now) && (now <= m_rsv_end[s]);
    endfunction

    // One clock edge: event pops at edge tp, is rolled at tp+1, placed at tp+2, retired at tp+3.
    task automatic model_step();
        bit idle_before = !m_inflight;
        int size_before = m_q.size();
        bit pop;
        t++;
        m_we = 3'b000;
        for (int i = 0; i < 3; i++)
            if (reserved(i, t) && slot_active[i]) m_rsv_end[i] = t;
        if (m_inflight) begin
            if (t == m_tp + 1) begin
                if (!(probability == 32'hFFFF_FFFF || m_lfsr < probability)) m_inflight = 0;
            end else if (t == m_tp + 2) begin
                m_sel = -1;
                for (int k = 0; k < 3; k++) begin
                    int s = (m_rr + k) % 3;
                    if (m_sel < 0 && !slot_active[s] && !reserved(s, t)) m_sel = s;
                end
                if (m_sel < 0) m_inflight = 0;
                else begin
                    m_we   = 3'(1 << m_sel);
                    m_addr = AW'(m_cur);
                end
            end else if (t == m_tp + 3) begin
                m_rsv_from[m_sel] = t;
                m_rsv_end[m_sel]  = t + RSV;
                m_rr              = (m_sel + 1) % 3;
                m_inflight        = 0;
            end
        end
        pop = idle_before && (size_before > 0);
        if (pop) begin
            m_cur = m_q.pop_front();
            m_tp = t;
            m_inflight = 1;
        end
        if (free_we) begin
            if (size_before < DEPTH || pop) m_q.push_back(int'(free_addr));
            else if (m_drop < 255) m_drop++;
        end
        m_busy = m_inflight || (m_q.size() != 0);
        m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        free_we = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bit seen = 0;
        apply_reset();
        n_tests++;
        if ({gen_we, gen_addr, fifo_count, drop_cnt, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b addr=%0d cnt=%0d drop=%0d busy=%b, want all 0",
                     gen_we, gen_addr, fifo_count, drop_cnt, busy);
        end
        probability = 32'hFFFF_FFFF; slot_active = 3'b000;
        free_we = 1'b1; free_addr = 8'd99;
        tick();
        free_we = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (gen_we != 3'b000) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_issue_wait: gen_we stayed 000, want an issue within 10 cycles");
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (gen_we !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async_we: got %b, want 000", gen_we);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        n_tests++;
        if ({fifo_count, drop_cnt, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got cnt=%0d drop=%0d busy=%b, want 0 0 0",
                     fifo_count, drop_cnt, busy);
        end
    endtask

    task automatic test_latency();
        logic [2:0] want;
        logic [AW-1:0] addrs [2];
        logic [2:0] slots [2];
        addrs[0] = 8'd37; addrs[1] = 8'd50;
        slots[0] = 3'b001; slots[1] = 3'b010;
        probability = 32'hFFFF_FFFF; slot_active = 3'b000;
        for (int e = 0; e < 2; e++) begin
            free_we = 1'b1; free_addr = addrs[e];
            for (int c = 1; c <= 5; c++) begin
                tick();
                free_we = 1'b0;
                want = (c == 4) ? slots[e] : 3'b000;
                n_tests++;
                if (gen_we !== want || (c == 4 && gen_addr !== addrs[e])) begin
                    n_fail++;
                    $display("FAIL latency_ev%0d_c%0d: got we=%b addr=%0d, want we=%b addr=%0d",
                             e, c, gen_we, gen_addr, want, addrs[e]);
                end
                n_tests++;
                if ({gen_we, gen_addr, fifo_count, drop_cnt, busy} !==
                    {m_we, m_addr, 3'(m_q.size()), 8'(m_drop), m_busy}) begin
                    n_fail++;
                    $display("FAIL latency_model: got %b/%0d/%0d/%0d/%b, want %b/%0d/%0d/%0d/%b",
                             gen_we, gen_addr, fifo_count, drop_cnt, busy,
                             m_we, m_addr, m_q.size(), m_drop, m_busy);
                end
            end
        end
    endtask

    task automatic test_zero_prob();
        probability = 32'h0; slot_active = 3'b000;
        for (int c = 0; c < 60; c++) begin
            free_we = (c < 20) && (c % 2 == 0);
            free_addr = 8'(c + 1);
            tick();
            n_tests++;
            if (gen_we !== 3'b000 || fifo_count !== 3'(m_q.size()) || busy !== m_busy) begin
                n_fail++;
                $display("FAIL zero_prob_c%0d: got we=%b cnt=%0d busy=%b, want 000 %0d %b",
                         c, gen_we, fifo_count, busy, m_q.size(), m_busy);
            end
        end
        free_we = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_prob_drain: got cnt=%0d busy=%b, want 0 0", fifo_count, busy);
        end
    endtask

    task automatic test_no_slot();
        int issues = 0;
        logic [2:0] got = '0;
        probability = 32'hFFFF_FFFF; slot_active = 3'b111;
        free_we = 1'b1; free_addr = 8'd12;
        for (int c = 0; c < 10; c++) begin
            tick();
            free_we = 1'b0;
            if (gen_we != 3'b000) issues++;
        end
        n_tests++;
        if (issues != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_slot_discard: got %0d issues busy=%b, want 0 issues busy=0",
                     issues, busy);
        end
        slot_active = 3'b101;
        free_we = 1'b1; free_addr = 8'd13;
        for (int c = 0; c < 10; c++) begin
            tick();
            free_we = 1'b0;
            if (gen_we != 3'b000) got = gen_we;
        end
        n_tests++;
        if (got !== 3'b010) begin
            n_fail++;
            $display("FAIL no_slot_freed: got we=%b, want 010", got);
        end
    endtask

    task automatic test_back_to_back();
        bit over = 0;
        probability = 32'h0; slot_active = 3'b000;
        for (int c = 0; c < 720; c++) begin
            free_we = (c < 8) || (c >= 20);
            free_addr = 8'($urandom_range(0, 208));
            tick();
            if (fifo_count > 3'd4) over = 1;
            n_tests++;
            if ({fifo_count, drop_cnt, busy} !== {3'(m_q.size()), 8'(m_drop), m_busy}) begin
                n_fail++;
                $display("FAIL overflow_c%0d: got cnt=%0d drop=%0d busy=%b, want %0d %0d %b",
                         c, fifo_count, drop_cnt, busy, m_q.size(), m_drop, m_busy);
            end
        end
        free_we = 1'b0;
        n_tests++;
        if (over || drop_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL overflow_saturate: got drop=%0d over=%0d, want drop=255 over=0",
                     drop_cnt, over);
        end
        for (int c = 0; c < 20; c++) tick();
    endtask

    task automatic test_reserve();
        int issues = 0;
        logic [AW-1:0] last = '0;
        logic [2:0] slot_seen = '0;
        probability = 32'hFFFF_FFFF; slot_active = 3'b110;
        for (int c = 0; c < 25; c++) begin
            free_we = (c < 3);
            free_addr = 8'(100 + c);
            tick();
            if (gen_we != 3'b000) begin issues++; last = gen_addr; slot_seen |= gen_we; end
            n_tests++;
            if ({gen_we, gen_addr, busy} !== {m_we, m_addr, m_busy}) begin
                n_fail++;
                $display("FAIL reserve_model_c%0d: got we=%b addr=%0d busy=%b, want %b %0d %b",
                         c, gen_we, gen_addr, busy, m_we, m_addr, m_busy);
            end
        end
        free_we = 1'b0;
        n_tests++;
        if (issues != 2 || last !== 8'd102 || slot_seen !== 3'b001) begin
            n_fail++;
            $display("FAIL reserve_skip: got %0d issues last=%0d slots=%b, want 2 102 001",
                     issues, last, slot_seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] probs [4];
        probs[0] = 32'h0; probs[1] = 32'hFFFF_FFFF; probs[2] = 32'h8000_0000;
        probs[3] = $urandom;
        for (int c = 0; c < 2400; c++) begin
            if (c % 300 == 0) probability = probs[(c / 300) % 4];
            free_we = ($urandom_range(0, 2) == 0);
            free_addr = 8'($urandom_range(0, 208));
            if ($urandom_range(0, 7) == 0) slot_active = 3'($urandom_range(0, 7));
            tick();
            n_tests++;
            if ({gen_we, gen_addr, fifo_count, drop_cnt, busy} !==
                {m_we, m_addr, 3'(m_q.size()), 8'(m_drop), m_busy} || !$onehot0(gen_we)) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b/%0d/%0d/%0d/%b, want %b/%0d/%0d/%0d/%b",
                         c, gen_we, gen_addr, fifo_count, drop_cnt, busy,
                         m_we, m_addr, m_q.size(), m_drop, m_busy);
            end
        end
        free_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_zero_prob();
        test_no_slot();
        test_back_to_back();
        test_reserve();
        apply_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
